// File: rtl/envelope_ch_scheduler.sv
// Round-robin scheduler that time-shares one envelope follower across NUM_CH
// sample channels: grant, leaky-accumulate |sample|, then publish a 6-bit level.
module envelope_ch_scheduler #(
    parameter int NUM_CH      = 4,
    parameter int IN_SHIFT    = 8,
    parameter int DECAY_SHIFT = 10,
    parameter int SCALE_SHIFT = 18
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      enable_i,
    input  logic                      clear_i,
    input  logic [NUM_CH-1:0]         ch_valid_i,
    input  logic [24*NUM_CH-1:0]      ch_sample_i,
    output logic [NUM_CH-1:0]         ch_ready_o,
    output logic [6*NUM_CH-1:0]       level6_o,
    output logic                      level_valid_o,
    output logic [$clog2(NUM_CH)-1:0] level_ch_o,
    output logic                      busy_o
);

    localparam int PTR_W = $clog2(NUM_CH);

    typedef enum logic [1:0] {IDLE, CALC, EMIT} state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]       hold_ch_q, hold_ch_d;
    logic [23:0]            hold_abs_q, hold_abs_d;
    logic [31:0]            acc_q [NUM_CH];
    logic [31:0]            acc_d [NUM_CH];
    logic [5:0]             level_q [NUM_CH];
    logic [5:0]             level_d [NUM_CH];

    logic                   grant_found;
    logic [PTR_W-1:0]       grant_idx;
    logic                   transfer;
    logic signed [23:0]     sel_sample;
    logic [31:0]            acc_next;

    function automatic logic [23:0] abs24(input logic signed [23:0] s);
        // Negating the most negative value wraps to 24'h800000, its true magnitude.
        return s[23] ? 24'(-s) : 24'(s);
    endfunction

    function automatic logic [31:0] sat_acc(input logic [32:0] sum);
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    function automatic logic [5:0] sat_level(input logic [31:0] acc);
        logic [31:0] scaled;
        scaled = acc >> SCALE_SHIFT;
        return (scaled > 32'd63) ? 6'd63 : scaled[5:0];
    endfunction

    // Round-robin search: first valid channel at or after rr_ptr, wrapping.
    always_comb begin
        int               cand;
        logic [PTR_W-1:0] cidx;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cidx        = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= NUM_CH) cand = cand - NUM_CH;
            cidx = PTR_W'(cand);
            if (!grant_found && ch_valid_i[cidx]) begin
                grant_found = 1'b1;
                grant_idx   = cidx;
            end
        end
    end

    assign transfer   = rst_ni && (state_q == IDLE) && enable_i && !clear_i && grant_found;
    assign sel_sample = ch_sample_i[int'(grant_idx)*24 +: 24];
    assign acc_next   = sat_acc({1'b0, acc_q[hold_ch_q]}
                                - {1'b0, acc_q[hold_ch_q] >> DECAY_SHIFT}
                                + 33'(hold_abs_q >> IN_SHIFT));

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (transfer) state_d = CALC;
                CALC:    state_d = EMIT;
                EMIT:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath next values; level follows the fresh accumulator so it is visible in EMIT.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        hold_ch_d  = hold_ch_q;
        hold_abs_d = hold_abs_q;
        acc_d      = acc_q;
        level_d    = level_q;
        if (clear_i) begin
            rr_ptr_d = '0;
            for (int k = 0; k < NUM_CH; k++) begin
                acc_d[k]   = '0;
                level_d[k] = '0;
            end
        end else begin
            if (transfer) begin
                hold_ch_d  = grant_idx;
                hold_abs_d = abs24(sel_sample);
                rr_ptr_d   = (grant_idx == PTR_W'(NUM_CH - 1)) ? '0 : grant_idx + PTR_W'(1);
            end
            if (state_q == CALC) begin
                acc_d[hold_ch_q]   = acc_next;
                level_d[hold_ch_q] = sat_level(acc_next);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                acc_q[k]   <= '0;
                level_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            acc_q    <= acc_d;
            level_q  <= level_d;
        end
    end

    // Holding registers are only read in CALC/EMIT after a capture, so no reset is needed.
    always_ff @(posedge clk_i) begin
        hold_ch_q  <= hold_ch_d;
        hold_abs_q <= hold_abs_d;
    end

    // Output logic
    always_comb begin
        busy_o        = (state_q != IDLE);
        level_valid_o = (state_q == EMIT) && !clear_i;
        level_ch_o    = level_valid_o ? hold_ch_q : '0;
        ch_ready_o    = transfer ? (NUM_CH'(1) << grant_idx) : '0;
        for (int k = 0; k < NUM_CH; k++) begin
            level6_o[6*k +: 6] = level_q[k];
        end
    end

endmodule

// File: doc/envelope_ch_scheduler.md
ENVELOPE_CH_SCHEDULER -- requirements
Module: envelope_ch_scheduler

Interface
REQ-001 Parameter NUM_CH, default 4: number of input channels sharing one envelope datapath (2..8).
REQ-002 Parameter IN_SHIFT, default 8: right shift applied to |sample|.
REQ-003 Parameter DECAY_SHIFT, default 10: leak shift of the accumulator.
REQ-004 Parameter SCALE_SHIFT, default 18: accumulator-to-level compression shift.
REQ-005 clk_i  in  1: single clock, rising edge.
REQ-006 rst_ni  in  1: reset, asynchronous, active-low.
REQ-007 enable_i  in  1: permits new grants when high.
REQ-008 clear_i  in  1: synchronous clear of all channel state.
REQ-009 ch_valid_i  in  NUM_CH: per-channel sample valid.
REQ-010 ch_sample_i  in  24*NUM_CH: signed two's-complement samples, channel k at bits [24k+23:24k].
REQ-011 ch_ready_o  out  NUM_CH: per-channel grant; transfer occurs when valid and ready are both high.
REQ-012 level6_o  out  6*NUM_CH: registered 6-bit envelope per channel, channel k at [6k+5:6k].
REQ-013 level_valid_o  out  1: one-cycle pulse when a level register updates.
REQ-014 level_ch_o  out  $clog2(NUM_CH): channel index of the update flagged by level_valid_o.
REQ-015 busy_o  out  1: high whenever FSM is not IDLE.

Function
REQ-016 FSM states: IDLE, CALC, EMIT; IDLE->CALC on a transfer, CALC->EMIT unconditionally, EMIT->IDLE unconditionally.
REQ-017 In IDLE with enable_i high and clear_i low, ch_ready_o is one-hot at the first valid channel at or after rr_ptr (wrapping modulo NUM_CH); otherwise ch_ready_o is all zero.
REQ-018 ch_ready_o is zero in CALC and EMIT; a non-granted valid channel is held off, never dropped by the block.
REQ-019 On transfer, the sample and channel index are captured into holding registers, and rr_ptr becomes granted index + 1 modulo NUM_CH.
REQ-020 CALC: acc[ch] <= acc[ch] - (acc[ch] >> DECAY_SHIFT) + (|sample| >> IN_SHIFT), computed at 33 bits and saturated to 32'hFFFFFFFF.
REQ-021 |sample| is 24-bit unsigned; -8388608 maps to 24'h800000.
REQ-022 EMIT: level[ch] <= 63 if (acc[ch] >> SCALE_SHIFT) > 63, else bits [5:0]; level_valid_o=1 and level_ch_o=ch in that cycle.
REQ-023 Latency: transfer in cycle T; acc updated at end of T+1; level6_o and level_valid_o visible in T+2; next transfer no earlier than T+3 (one sample per 3 cycles).
REQ-024 Per-channel accumulators (32-bit) and levels are held in NUM_CH-entry register arrays; only the granted entry changes.
REQ-025 enable_i low blocks new grants only; an operation in CALC or EMIT completes.
REQ-026 clear_i high: all acc and level entries zero, FSM to IDLE, rr_ptr to 0, level_valid_o low, ch_ready_o zero in that cycle; any in-flight operation is discarded.
REQ-027 clear_i overrides a simultaneous valid/ready transfer and a simultaneous EMIT.
REQ-028 busy_o = (state != IDLE), combinational from state.

Reset
REQ-029 While rst_ni is low: state IDLE, rr_ptr 0, all acc 0, all level6_o 0, level_valid_o 0, level_ch_o 0, ch_ready_o 0, busy_o 0.
REQ-030 Reset asserted mid-operation aborts immediately; no level update follows deassertion.
REQ-031 After deassertion, the first grant may occur in the first clock edge with enable_i high.

Verification (SCALE_SHIFT overridden to 10, NUM_CH=4)
REQ-032 Ch0 sample -8388608 once -> transfer at T, level_valid_o at T+2, level_ch_o=0, level6_o[ch0]=32 (acc=32768).
REQ-033 Two more identical ch0 samples -> acc 65504 then level 63; third yields acc 98209, level saturates at 63.
REQ-034 All four channels valid continuously after reset -> grants in order 0,1,2,3,0, spaced exactly 3 cycles apart, ch_ready_o always one-hot.
REQ-035 Ch2 valid with enable_i low for 10 cycles -> ch_ready_o stays 0, busy_o 0; enable_i high -> grant ch2 next cycle.
REQ-036 clear_i pulsed during CALC of ch1 (levels nonzero) -> all level6_o 0, no level_valid_o pulse, rr_ptr 0.
REQ-037 rst_ni asserted in EMIT cycle -> outputs at REQ-029 values asynchronously, before the next clock edge.
